// File: rtl/mc_maindec_if.sv
// Decoder <-> datapath bundle: opcode/handshake in, mux and enable controls out.
interface mc_maindec_if #(
  parameter int CNT_W = 32,
  parameter int OP_W  = 11
);
  logic [OP_W-1:0]  Op;
  logic             mem_ready;
  logic             IRWrite, PCWrite, BranchZ, BranchNZ, PCSrc;
  logic             Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB, ALUOp;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;
  logic             exc_valid;
  logic [OP_W-1:0]  exc_op;

  modport slave (
    input  Op, mem_ready,
    output IRWrite, PCWrite, BranchZ, BranchNZ, PCSrc, Reg2Loc, MemtoReg,
           RegWrite, MemRead, MemWrite, ALUSrcA, ALUSrcB, ALUOp, state,
           instret, exc_valid, exc_op
  );

  modport master (
    output Op, mem_ready,
    input  IRWrite, PCWrite, BranchZ, BranchNZ, PCSrc, Reg2Loc, MemtoReg,
           RegWrite, MemRead, MemWrite, ALUSrcA, ALUSrcB, ALUOp, state,
           instret, exc_valid, exc_op
  );
endinterface

// File: rtl/mc_maindec.sv
// Multicycle LEGv8 main control FSM with retired-instruction counter.
// Define LEGV8_EXC_EN to route unknown opcodes through the EXC state (exc_valid pulse).
module mc_maindec #(
  parameter int CNT_W = 32,
  parameter int OP_W  = 11
) (
  input  logic        clk,
  input  logic        reset,
  mc_maindec_if.slave bus
);

  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADDR = 4'd2, MEMRD = 4'd3, LDWB = 4'd4,
    MEMWR = 4'd5, EXEC = 4'd6, ALUWB = 4'd7, BRANCH = 4'd8, EXC = 4'd9
  } state_t;

  typedef enum logic [2:0] {
    C_LD, C_ST, C_R, C_I, C_CBZ, C_CBNZ, C_B, C_ILL
  } cls_t;

  state_t           state_q, state_d;
  cls_t             cls_q, cls_dec;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [OP_W-1:0]  op_w;

  logic       irw, pcw, bz, bnz, pcs, r2l, m2r, rw, mr, mw, asa, excv;
  logic [1:0] asb, aop;

  assign op_w = bus.Op;

  always_comb begin
    cls_dec = C_ILL;
    casez (op_w)
      11'b11111000010: cls_dec = C_LD;
      11'b11111000000: cls_dec = C_ST;
      11'b10001011000,
      11'b11001011000,
      11'b10001010000,
      11'b10101010000: cls_dec = C_R;
      11'b1001000100?: cls_dec = C_I;
      11'b10110100???: cls_dec = C_CBZ;
      11'b10110101???: cls_dec = C_CBNZ;
      11'b000101?????: cls_dec = C_B;
      default:         cls_dec = C_ILL;
    endcase
  end

  // Later states steer on cls_q so the IR may change once DECODE is done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      cls_q     <= C_ILL;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
      if (state_q == DECODE) cls_q <= cls_dec;
    end
  end

`ifdef LEGV8_EXC_EN
  logic [OP_W-1:0] op_q;
  always_ff @(posedge clk) begin
    if (reset)                  op_q <= '0;
    else if (state_q == DECODE) op_q <= op_w;
  end
  assign bus.exc_op = op_q;
`else
  assign bus.exc_op = '0;
`endif

  always_comb begin
    state_d = state_q;
    irw = 1'b0; pcw = 1'b0; bz = 1'b0; bnz = 1'b0; pcs = 1'b0;
    r2l = 1'b0; m2r = 1'b0; rw = 1'b0; mr = 1'b0; mw = 1'b0;
    asa = 1'b0; asb = 2'b00; aop = 2'b00; excv = 1'b0;
    case (state_q)
      FETCH: begin
        mr  = 1'b1;
        asb = 2'b01;
        irw = bus.mem_ready;
        pcw = bus.mem_ready;
        if (bus.mem_ready) state_d = DECODE;
      end
      DECODE: begin
        asb = 2'b11;
        case (cls_dec)
          C_LD, C_ST:         state_d = MEMADDR;
          C_R, C_I:           state_d = EXEC;
          C_CBZ, C_CBNZ, C_B: state_d = BRANCH;
`ifdef LEGV8_EXC_EN
          default:            state_d = EXC;
`else
          default:            state_d = FETCH;
`endif
        endcase
      end
      MEMADDR: begin
        asa = 1'b1;
        asb = 2'b10;
        r2l = (cls_q == C_ST);
        state_d = (cls_q == C_ST) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        mr = 1'b1;
        if (bus.mem_ready) state_d = LDWB;
      end
      LDWB: begin
        rw  = 1'b1;
        m2r = 1'b1;
        state_d = FETCH;
      end
      MEMWR: begin
        mw  = 1'b1;
        r2l = 1'b1;
        if (bus.mem_ready) state_d = FETCH;
      end
      EXEC: begin
        asa = 1'b1;
        if (cls_q == C_R) aop = 2'b10;
        else              asb = 2'b10;
        state_d = ALUWB;
      end
      ALUWB: begin
        rw = 1'b1;
        state_d = FETCH;
      end
      BRANCH: begin
        r2l = 1'b1;
        asa = 1'b1;
        aop = 2'b01;
        pcs = 1'b1;
        bz  = (cls_q == C_CBZ);
        bnz = (cls_q == C_CBNZ);
        pcw = (cls_q == C_B);
        state_d = FETCH;
      end
`ifdef LEGV8_EXC_EN
      EXC: begin
        excv    = 1'b1;
        state_d = FETCH;
      end
`endif
      default: state_d = FETCH;
    endcase
  end

  // Only completed instructions retire; ILL/EXC paths into FETCH do not count.
  always_comb begin
    instret_d = instret_q;
    if (state_d == FETCH &&
        (state_q == LDWB || state_q == MEMWR || state_q == ALUWB || state_q == BRANCH))
      instret_d = instret_q + 1'b1;
  end

  // Reset forces every control to 0 immediately, even mid-instruction.
  always_comb begin
    bus.IRWrite   = irw & ~reset;
    bus.PCWrite   = pcw & ~reset;
    bus.BranchZ   = bz  & ~reset;
    bus.BranchNZ  = bnz & ~reset;
    bus.PCSrc     = pcs & ~reset;
    bus.Reg2Loc   = r2l & ~reset;
    bus.MemtoReg  = m2r & ~reset;
    bus.RegWrite  = rw  & ~reset;
    bus.MemRead   = mr  & ~reset;
    bus.MemWrite  = mw  & ~reset;
    bus.ALUSrcA   = asa & ~reset;
    bus.ALUSrcB   = reset ? 2'b00 : asb;
    bus.ALUOp     = reset ? 2'b00 : aop;
    bus.state     = reset ? 4'd0 : state_q;
    bus.exc_valid = excv & ~reset;
    bus.instret   = instret_q;
  end

endmodule

// File: tb/tb_mc_maindec.sv
// Table-driven check of mc_maindec (CNT_W=32 and CNT_W=4 copies on shared stimulus).
module tb_mc_maindec;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mc_maindec_if #(.CNT_W(32), .OP_W(11)) bif  ();
  mc_maindec_if #(.CNT_W(4),  .OP_W(11)) bif4 ();

  mc_maindec #(.CNT_W(32), .OP_W(11)) dut  (.clk(clk), .reset(reset), .bus(bif));
  mc_maindec #(.CNT_W(4),  .OP_W(11)) dut4 (.clk(clk), .reset(reset), .bus(bif4));

  localparam logic [10:0] ADD  = 11'b10001011000, SUB  = 11'b11001011000;
  localparam logic [10:0] ANDo = 11'b10001010000, ORR  = 11'b10101010000;
  localparam logic [10:0] LDUR = 11'b11111000010, STUR = 11'b11111000000;
  localparam logic [10:0] ADDI = 11'b10010001001, CBZ  = 11'b10110100111;
  localparam logic [10:0] CBNZ = 11'b10110101010, BOP  = 11'b00010110011;
  localparam logic [10:0] ILL  = 11'b00000000000;

  // {IRWrite,PCWrite,BranchZ,BranchNZ,PCSrc,Reg2Loc,MemtoReg,RegWrite,MemRead,MemWrite,ALUSrcA,ALUSrcB,ALUOp}
  localparam logic [14:0] Z     = 15'b0;
  localparam logic [14:0] F_R   = {1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,2'b00};
  localparam logic [14:0] F_W   = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,2'b01,2'b00};
  localparam logic [14:0] DEC   = {11'b0,2'b11,2'b00};
  localparam logic [14:0] MA_LD = {10'b0,1'b1,2'b10,2'b00};
  localparam logic [14:0] MA_ST = {5'b0,1'b1,4'b0,1'b1,2'b10,2'b00};
  localparam logic [14:0] MRD   = {8'b0,1'b1,6'b0};
  localparam logic [14:0] LDWB  = {6'b0,1'b1,1'b1,7'b0};
  localparam logic [14:0] MWR   = {5'b0,1'b1,3'b0,1'b1,5'b0};
  localparam logic [14:0] EX_R  = {10'b0,1'b1,2'b00,2'b10};
  localparam logic [14:0] EX_I  = {10'b0,1'b1,2'b10,2'b00};
  localparam logic [14:0] AWB   = {7'b0,1'b1,7'b0};
  localparam logic [14:0] BR_Z  = {2'b00,1'b1,1'b0,1'b1,1'b1,4'b0,1'b1,2'b00,2'b01};
  localparam logic [14:0] BR_NZ = {2'b00,1'b0,1'b1,1'b1,1'b1,4'b0,1'b1,2'b00,2'b01};
  localparam logic [14:0] BR_B  = {2'b01,1'b0,1'b0,1'b1,1'b1,4'b0,1'b1,2'b00,2'b01};

  typedef struct {
    logic        rst;
    logic [10:0] op;
    logic        rdy;
    logic [3:0]  st;
    logic [14:0] ctl;
    logic        exc;
    int          ir;
  } vec_t;

  vec_t vq[$];
  int errors = 0;
  int checks = 0;

  logic [14:0] ctl32, ctl4;
  assign ctl32 = {bif.IRWrite, bif.PCWrite, bif.BranchZ, bif.BranchNZ, bif.PCSrc,
                  bif.Reg2Loc, bif.MemtoReg, bif.RegWrite, bif.MemRead, bif.MemWrite,
                  bif.ALUSrcA, bif.ALUSrcB, bif.ALUOp};
  assign ctl4  = {bif4.IRWrite, bif4.PCWrite, bif4.BranchZ, bif4.BranchNZ, bif4.PCSrc,
                  bif4.Reg2Loc, bif4.MemtoReg, bif4.RegWrite, bif4.MemRead, bif4.MemWrite,
                  bif4.ALUSrcA, bif4.ALUSrcB, bif4.ALUOp};

  task automatic add(input logic rst, input logic [10:0] op, input logic rdy,
                     input logic [3:0] st, input logic [14:0] ctl, input logic exc,
                     input int ir);
    vec_t v;
    v.rst = rst; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl; v.exc = exc; v.ir = ir;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic [10:0] op, input logic rdy);
    reset = rst;
    bif.Op = op;  bif.mem_ready = rdy;
    bif4.Op = op; bif4.mem_ready = rdy;
  endtask

  initial begin
    drive(1'b1, ADD, 1'b1);

    // reset then ADD
    add(1, ADD, 1, 0, Z, 0, 0);
    add(0, ADD, 1, 0, F_R, 0, 0);   add(0, ADD, 1, 1, DEC, 0, 0);
    add(0, ADD, 1, 6, EX_R, 0, 0);  add(0, ADD, 1, 7, AWB, 0, 0);
    // LDUR with two wait cycles in MEMRD
    add(0, LDUR, 1, 0, F_R, 0, 1);  add(0, LDUR, 1, 1, DEC, 0, 1);
    add(0, LDUR, 1, 2, MA_LD, 0, 1);
    add(0, LDUR, 0, 3, MRD, 0, 1);  add(0, LDUR, 0, 3, MRD, 0, 1);
    add(0, LDUR, 1, 3, MRD, 0, 1);  add(0, LDUR, 1, 4, LDWB, 0, 1);
    // CBNZ, B, CBZ
    add(0, CBNZ, 1, 0, F_R, 0, 2);  add(0, CBNZ, 1, 1, DEC, 0, 2);
    add(0, CBNZ, 1, 8, BR_NZ, 0, 2);
    add(0, BOP, 1, 0, F_R, 0, 3);   add(0, BOP, 1, 1, DEC, 0, 3);
    add(0, BOP, 1, 8, BR_B, 0, 3);
    add(0, CBZ, 1, 0, F_R, 0, 4);   add(0, CBZ, 1, 1, DEC, 0, 4);
    add(0, CBZ, 1, 8, BR_Z, 0, 4);
    // STUR with one fetch wait cycle
    add(0, STUR, 0, 0, F_W, 0, 5);  add(0, STUR, 1, 0, F_R, 0, 5);
    add(0, STUR, 1, 1, DEC, 0, 5);  add(0, STUR, 1, 2, MA_ST, 0, 5);
    add(0, STUR, 1, 5, MWR, 0, 5);
    // ADDI
    add(0, ADDI, 1, 0, F_R, 0, 6);  add(0, ADDI, 1, 1, DEC, 0, 6);
    add(0, ADDI, 1, 6, EX_I, 0, 6); add(0, ADDI, 1, 7, AWB, 0, 6);
    // unknown opcode
    add(0, ILL, 1, 0, F_R, 0, 7);   add(0, ILL, 1, 1, DEC, 0, 7);
`ifdef LEGV8_EXC_EN
    add(0, ILL, 1, 9, Z, 1, 7);
`endif
    // STUR abandoned by reset in MEMWR
    add(0, STUR, 1, 0, F_R, 0, 7);  add(0, STUR, 1, 1, DEC, 0, 7);
    add(0, STUR, 1, 2, MA_ST, 0, 7); add(0, STUR, 0, 5, MWR, 0, 7);
    add(1, STUR, 0, 0, Z, 0, 7);    add(1, STUR, 0, 0, Z, 0, 0);
    // AND, ORR, SUB back to back
    add(0, ANDo, 1, 0, F_R, 0, 0);  add(0, ANDo, 1, 1, DEC, 0, 0);
    add(0, ANDo, 1, 6, EX_R, 0, 0); add(0, ANDo, 1, 7, AWB, 0, 0);
    add(0, ORR, 1, 0, F_R, 0, 1);   add(0, ORR, 1, 1, DEC, 0, 1);
    add(0, ORR, 1, 6, EX_R, 0, 1);  add(0, ORR, 1, 7, AWB, 0, 1);
    add(0, SUB, 1, 0, F_R, 0, 2);   add(0, SUB, 1, 1, DEC, 0, 2);
    add(0, SUB, 1, 6, EX_R, 0, 2);  add(0, SUB, 1, 7, AWB, 0, 2);
    add(0, SUB, 1, 0, F_R, 0, 3);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i].rst, vq[i].op, vq[i].rdy);
      #1;
      chk("state",     i, {28'b0, bif.state}, {28'b0, vq[i].st});
      chk("ctl",       i, {17'b0, ctl32},     {17'b0, vq[i].ctl});
      chk("exc_valid", i, {31'b0, bif.exc_valid}, {31'b0, vq[i].exc});
      chk("instret",   i, bif.instret, vq[i].ir);
      chk("ctl4",      i, {17'b0, ctl4},      {17'b0, vq[i].ctl});
      chk("instret4",  i, {28'b0, bif4.instret}, {28'b0, vq[i].ir[3:0]});
`ifdef LEGV8_EXC_EN
      if (vq[i].exc) chk("exc_op", i, {21'b0, bif.exc_op}, {21'b0, vq[i].op});
`endif
    end

    // 16 back-to-back ADDIs: 4-bit counter wraps 15 -> 0
    @(negedge clk); drive(1'b1, ADDI, 1'b1);
    @(negedge clk); drive(1'b0, ADDI, 1'b1);
    repeat (60) @(negedge clk);
    #1;
    chk("wrap_pre4",  100, {28'b0, bif4.instret}, 32'd15);
    chk("wrap_pre32", 100, bif.instret, 32'd15);
    repeat (4) @(negedge clk);
    #1;
    chk("wrap_post4",  101, {28'b0, bif4.instret}, 32'd0);
    chk("wrap_post32", 101, bif.instret, 32'd16);
    chk("wrap_state",  101, {28'b0, bif4.state}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mc_maindec.md
# mc_maindec

Multicycle main control FSM for the LEGv8 datapath. It is the successor to the single-cycle main decoder: it steps each instruction through fetch, decode, execute, memory and writeback states. It waits on a memory-ready handshake and decodes a wider opcode set (adds CBNZ, B, ADDI). It also counts retired instructions. It sits between the instruction register's opcode field and the multicycle datapath's mux and enable controls.

## Interface
Parameters:
- CNT_W, 32, width of retired-instruction counter
- OP_W, 11, opcode field width (instr[31:21]); must be 11

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- Op  in  OP_W  opcode from instruction register
- mem_ready  in  1  memory completes current read/write this cycle
- IRWrite, PCWrite  out  1  load IR / unconditional PC load
- BranchZ, BranchNZ  out  1  conditional PC load if ALU zero / not zero
- PCSrc  out  1  0 = ALU result (PC+4), 1 = ALUOut (branch target)
- Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite  out  1  as in single-cycle decoder
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 reg B, 01 const 4, 10 sign-ext imm, 11 branch offset <<2
- ALUOp  out  2  00 add, 01 pass B, 10 funct-decoded
- state  out  4  current state encoding (debug)
- instret  out  CNT_W  retired-instruction count
- exc_valid  out  1  unknown-opcode pulse (see Configuration)

## Operation
- States: FETCH=0, DECODE=1, MEMADDR=2, MEMRD=3, LDWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, EXC=9.
- Decode (casez on Op):
  - LDUR 11111000010, STUR 11111000000 -> MEM class.
  - ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000 -> R class.
  - ADDI 1001000100? -> I class.
  - CBZ 10110100??? -> CBZ class; CBNZ 10110101??? -> CBNZ class.
  - B 000101????? -> B class.
  - Any other opcode -> ILL class.
- The class is registered on leaving DECODE. Later states use the registered class, not Op.
- Moore outputs; any output not listed below is 0.
  - FETCH: MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00. IRWrite and PCWrite equal mem_ready. Stays in FETCH until mem_ready, then goes to DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by class: MEM->MEMADDR, R/I->EXEC, CBZ/CBNZ/B->BRANCH, ILL->EXC or FETCH.
  - MEMADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. STUR also drives Reg2Loc=1. Next is MEMRD for LDUR, MEMWR for STUR.
  - MEMRD: MemRead=1. Holds until mem_ready, then LDWB.
  - LDWB: RegWrite=1, MemtoReg=1. Next is FETCH.
  - MEMWR: MemWrite=1, Reg2Loc=1. Holds until mem_ready, then FETCH.
  - EXEC: ALUSrcA=1. R class: ALUSrcB=00, ALUOp=10. I class: ALUSrcB=10, ALUOp=00. Next is ALUWB.
  - ALUWB: RegWrite=1, MemtoReg=0. Next is FETCH.
  - BRANCH: Reg2Loc=1, ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=1. CBZ drives BranchZ, CBNZ drives BranchNZ, B drives PCWrite. Next is FETCH.
- instret increments by 1 on each transition into FETCH from LDWB, MEMWR, ALUWB or BRANCH. It wraps modulo 2^CNT_W. It does not increment after ILL or EXC.

## Timing
- Cycles per instruction with zero memory wait:
  - R/ADDI: 4
  - LDUR: 5
  - STUR: 4
  - CBZ/CBNZ/B: 3
- Each cycle mem_ready is low in FETCH, MEMRD or MEMWR adds one cycle. Outputs are held stable across those wait cycles.
- mem_ready is ignored in all other states.
- Reset: state=FETCH and instret=0 at the edge where reset is high. While reset is high, every control output is 0, state reads 0 and exc_valid=0. This applies mid-instruction as well; pending memory operations are abandoned.
- First fetch: MemRead rises in the first cycle after reset deasserts.

## Configuration
- LEGV8_EXC_EN defined: ILL class goes DECODE->EXC->FETCH.
  - In EXC, exc_valid=1 for exactly one cycle and all other controls are 0.
  - Op is latched at DECODE so external logic can sample it during EXC.
- LEGV8_EXC_EN undefined: ILL class goes DECODE->FETCH (treated as a NOP). The EXC state is not built and exc_valid is tied 0.

## Test plan
- Reset, then ADD (10001011000) with mem_ready=1: states 0,1,6,7,0. ALUOp=10 in EXEC, RegWrite=1 in ALUWB, instret 0->1.
- LDUR with mem_ready low for 2 cycles in MEMRD: MEMRD lasts 3 cycles with MemRead held at 1. LDWB follows with MemtoReg=1. Total 7 cycles.
- CBNZ (10110101xxx): BRANCH has BranchNZ=1, BranchZ=0, PCWrite=0, PCSrc=1. B (000101xxxxx): PCWrite=1 in BRANCH.
- Opcode 00000000000:
  - With LEGV8_EXC_EN: one-cycle exc_valid=1 in state 9, instret unchanged.
  - Without it: DECODE returns to FETCH, exc_valid stays 0.
- Reset asserted during MEMWR: the next cycle is FETCH with all outputs 0 while reset is high, and instret=0.
- CNT_W=4, 16 back-to-back ADDI: instret wraps 15->0.
